// File: rtl/hazard_ctrl_pkg.sv
// Shared core types for the 5-stage pipeline controller: register control
// encoding, hazard FSM states and the canonical NOP encoding.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    CONTINUE = 2'd0,
    STALL    = 2'd1,
    FLUSH    = 2'd2
  } pipeline_control_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && !(&count_q))
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch / memory-wait resolution,
// debug halt-drain-resume FSM, and saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 255,
  parameter int DRAIN_CYCLES   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs2_i,
  input  logic                      d_use_rs1_i,
  input  logic                      d_use_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] e_rd_i,
  input  logic                      e_is_load_i,
  input  logic                      e_branch_taken_i,
  input  logic                      dmem_req_i,
  input  logic                      dmem_ack_i,
  input  logic                      halt_req_i,
  input  logic                      resume_i,
  output pipeline_control_t         ctrl_fd_o,
  output pipeline_control_t         ctrl_de_o,
  output pipeline_control_t         ctrl_em_o,
  output pipeline_control_t         ctrl_mw_o,
  output logic                      pc_en_o,
  output logic                      halted_o,
  output logic                      mem_timeout_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  hazard_state_t      state_d, state_q;
  logic [DRAIN_W-1:0] drain_d, drain_q;
  logic               timeout_d, timeout_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               mem_wait, load_use, branch_flush;

  assign mem_wait = dmem_req_i & ~dmem_ack_i;
  assign load_use = e_is_load_i & (e_rd_i != '0) &
                    ((d_use_rs1_i & (d_rs1_i == e_rd_i)) |
                     (d_use_rs2_i & (d_rs2_i == e_rd_i)));

  always_comb begin
    ctrl_fd_o    = CONTINUE;
    ctrl_de_o    = CONTINUE;
    ctrl_em_o    = CONTINUE;
    ctrl_mw_o    = CONTINUE;
    pc_en_o      = 1'b1;
    halted_o     = 1'b0;
    branch_flush = 1'b0;
    if (rst_i) begin
      ctrl_fd_o = FLUSH;
      ctrl_de_o = FLUSH;
      ctrl_em_o = FLUSH;
      ctrl_mw_o = FLUSH;
      pc_en_o   = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            ctrl_fd_o = STALL;
            ctrl_de_o = STALL;
            ctrl_em_o = STALL;
            ctrl_mw_o = FLUSH;
            pc_en_o   = 1'b0;
          end else if (e_branch_taken_i) begin
            ctrl_fd_o    = FLUSH;
            ctrl_de_o    = FLUSH;
            branch_flush = 1'b1;
          end else if (load_use) begin
            ctrl_fd_o = STALL;
            ctrl_de_o = FLUSH;
            pc_en_o   = 1'b0;
          end
        end
        DRAIN: begin
          // Fetch is starved so decode only ever receives bubbles.
          ctrl_fd_o = FLUSH;
          pc_en_o   = 1'b0;
          if (mem_wait) begin
            ctrl_de_o = STALL;
            ctrl_em_o = STALL;
            ctrl_mw_o = FLUSH;
          end else if (e_branch_taken_i) begin
            ctrl_de_o    = FLUSH;
            pc_en_o      = 1'b1;
            branch_flush = 1'b1;
          end else if (load_use) begin
            ctrl_de_o = FLUSH;
          end
        end
        HALTED: begin
          ctrl_fd_o = STALL;
          ctrl_de_o = STALL;
          ctrl_em_o = STALL;
          ctrl_mw_o = STALL;
          pc_en_o   = 1'b0;
          halted_o  = 1'b1;
        end
        default: begin
          ctrl_fd_o = FLUSH;
          ctrl_de_o = FLUSH;
          ctrl_em_o = FLUSH;
          ctrl_mw_o = FLUSH;
          pc_en_o   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    // Flag rises on the same edge the wait counter reaches MEM_TIMEOUT.
    timeout_d = timeout_q | (mem_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)));
    case (state_q)
      RUN: begin
        if (halt_req_i) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (!mem_wait) begin
          if (drain_q <= DRAIN_W'(1)) begin
            state_d = HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      HALTED: begin
        if (resume_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      drain_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout_o = timeout_q;

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (mem_wait),
    .clr_i   (~mem_wait),
    .count_o (wait_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   ((state_q == RUN) & ~pc_en_o),
    .clr_i   (1'b0),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (branch_flush),
    .clr_i   (1'b0),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazards, memory timeout, halt/drain/resume
// and reset behaviour, with hand-computed expectations.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        d_rs1, d_rs2, e_rd;
  logic              d_use_rs1, d_use_rs2, e_is_load, e_br;
  logic              dmem_req, dmem_ack, halt_req, resume;
  pipeline_control_t ctrl_fd, ctrl_de, ctrl_em, ctrl_mw;
  logic              pc_en, halted, mem_timeout;
  logic [31:0]       stall_cnt, flush_cnt;
  logic [8:0]        ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] C_RUN = {CONTINUE, CONTINUE, CONTINUE, CONTINUE, 1'b1};
  localparam logic [8:0] C_LU  = {STALL, FLUSH, CONTINUE, CONTINUE, 1'b0};
  localparam logic [8:0] C_BR  = {FLUSH, FLUSH, CONTINUE, CONTINUE, 1'b1};
  localparam logic [8:0] C_MW  = {STALL, STALL, STALL, FLUSH, 1'b0};
  localparam logic [8:0] C_DRN = {FLUSH, CONTINUE, CONTINUE, CONTINUE, 1'b0};
  localparam logic [8:0] C_DMW = {FLUSH, STALL, STALL, FLUSH, 1'b0};
  localparam logic [8:0] C_HLT = {STALL, STALL, STALL, STALL, 1'b0};
  localparam logic [8:0] C_RST = {FLUSH, FLUSH, FLUSH, FLUSH, 1'b0};

  assign ctl = {ctrl_fd, ctrl_de, ctrl_em, ctrl_mw, pc_en};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_WIDTH(5), .CNT_WIDTH(32), .MEM_TIMEOUT(255), .DRAIN_CYCLES(3)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_use_rs1_i(d_use_rs1), .d_use_rs2_i(d_use_rs2),
    .e_rd_i(e_rd), .e_is_load_i(e_is_load), .e_branch_taken_i(e_br),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .halt_req_i(halt_req), .resume_i(resume),
    .ctrl_fd_o(ctrl_fd), .ctrl_de_o(ctrl_de), .ctrl_em_o(ctrl_em), .ctrl_mw_o(ctrl_mw),
    .pc_en_o(pc_en), .halted_o(halted), .mem_timeout_o(mem_timeout),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic idle();
    d_rs1 = 0; d_rs2 = 0; e_rd = 0; d_use_rs1 = 0; d_use_rs2 = 0;
    e_is_load = 0; e_br = 0; dmem_req = 0; dmem_ack = 0; halt_req = 0; resume = 0;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    e_br = 1'b1; dmem_req = 1'b1;
    repeat (2) next_cycle();
    #1;
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_RST); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", mem_timeout); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnts got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    next_cycle();
    rst = 1'b0; idle(); #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL post_reset_ctl got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_load_use();
    next_cycle();
    e_is_load = 1; e_rd = 5; d_rs1 = 5; d_use_rs1 = 1; #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1 got %b want %b", ctl, C_LU); end
    next_cycle();
    idle(); #1;
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_one_bubble got %b want %b", ctl, C_RUN); end
    e_is_load = 1; e_rd = 0; d_rs1 = 0; d_use_rs1 = 1; #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_x0 got %b want %b", ctl, C_RUN); end
    next_cycle();
    idle(); e_is_load = 1; e_rd = 7; d_rs2 = 7; d_use_rs2 = 1; d_rs1 = 3; d_use_rs1 = 1; #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2 got %b want %b", ctl, C_LU); end
    next_cycle();
    idle(); e_is_load = 1; e_rd = 7; d_rs2 = 7; d_use_rs2 = 0; #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_unused_rs2 got %b want %b", ctl, C_RUN); end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL lu_stall_cnt2 got %0d want 2", stall_cnt); end
    idle(); e_rd = 7; d_rs1 = 7; d_use_rs1 = 1; #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_not_load got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_branch();
    next_cycle();
    idle(); e_is_load = 1; e_rd = 9; d_rs1 = 9; d_use_rs1 = 1; e_br = 1; #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_over_lu got %b want %b", ctl, C_BR); end
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL br_flush_pre got %0d want 0", flush_cnt); end
    next_cycle();
    idle(); #1;
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL br_flush_cnt got %0d want 1", flush_cnt); end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL br_stall_cnt got %0d want 2", stall_cnt); end
  endtask

  task automatic test_mem_timeout();
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      idle(); dmem_req = 1; dmem_ack = 0; e_br = (i == 10); #1;
      checks++; if (ctl !== C_MW) begin errors++; $display("FAIL mw_ctl cyc %0d got %b want %b", i, ctl, C_MW); end
      checks++; if (mem_timeout !== (i >= 255)) begin errors++; $display("FAIL mw_timeout cyc %0d got %b want %b", i, mem_timeout, (i >= 255)); end
    end
    next_cycle();
    idle(); dmem_req = 1; dmem_ack = 1; #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL mw_ack got %b want %b", ctl, C_RUN); end
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL mw_sticky got %b want 1", mem_timeout); end
    checks++; if (stall_cnt !== 32'd302) begin errors++; $display("FAIL mw_stall_cnt got %0d want 302", stall_cnt); end
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL mw_br_masked got %0d want 1", flush_cnt); end
    next_cycle();
    idle(); #1;
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL mw_sticky2 got %b want 1", mem_timeout); end
  endtask

  task automatic test_halt_resume();
    next_cycle();
    idle(); halt_req = 1; #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL halt_req_cyc got %b want %b", ctl, C_RUN); end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      idle(); #1;
      checks++; if (ctl !== C_DRN || halted !== 1'b0) begin errors++; $display("FAIL drain_%0d got %b/%b want %b/0", k, ctl, halted, C_DRN); end
    end
    next_cycle();
    idle(); halt_req = 1; #1;
    checks++; if (ctl !== C_HLT || halted !== 1'b1) begin errors++; $display("FAIL halted got %b/%b want %b/1", ctl, halted, C_HLT); end
    next_cycle();
    idle(); resume = 1; #1;
    checks++; if (ctl !== C_HLT || halted !== 1'b1) begin errors++; $display("FAIL halt_ignores_req got %b/%b want %b/1", ctl, halted, C_HLT); end
    next_cycle();
    idle(); #1;
    checks++; if (ctl !== C_RUN || halted !== 1'b0) begin errors++; $display("FAIL resumed got %b/%b want %b/0", ctl, halted, C_RUN); end
    checks++; if (stall_cnt !== 32'd302) begin errors++; $display("FAIL halt_no_stall_cnt got %0d want 302", stall_cnt); end
  endtask

  task automatic test_halt_branch();
    next_cycle();
    idle(); halt_req = 1; e_br = 1; #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL halt_br got %b want %b", ctl, C_BR); end
    next_cycle();
    idle(); e_br = 1; #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL drain_br got %b want %b", ctl, C_BR); end
    checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL halt_br_cnt got %0d want 2", flush_cnt); end
    next_cycle();
    idle(); e_is_load = 1; e_rd = 4; d_rs2 = 4; d_use_rs2 = 1; #1;
    checks++; if (ctl !== {FLUSH, FLUSH, CONTINUE, CONTINUE, 1'b0}) begin errors++; $display("FAIL drain_lu got %b want %b", ctl, {FLUSH, FLUSH, CONTINUE, CONTINUE, 1'b0}); end
    checks++; if (flush_cnt !== 32'd3) begin errors++; $display("FAIL drain_br_cnt got %0d want 3", flush_cnt); end
    next_cycle();
    idle(); #1;
    checks++; if (ctl !== C_DRN) begin errors++; $display("FAIL drain_last got %b want %b", ctl, C_DRN); end
    next_cycle();
    idle(); resume = 1; #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_br_halted got %b want 1", halted); end
    next_cycle();
    idle(); #1;
    checks++; if (halted !== 1'b0 || ctl !== C_RUN) begin errors++; $display("FAIL halt_br_resume got %b/%b want 0/%b", halted, ctl, C_RUN); end
  endtask

  task automatic test_drain_mem_wait();
    next_cycle();
    idle(); halt_req = 1; #1;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      idle(); dmem_req = (k <= 2); #1;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL dmw_early_halt k %0d got %b want 0", k, halted); end
      if (k <= 2) begin
        checks++; if (ctl !== C_DMW) begin errors++; $display("FAIL dmw_ctl k %0d got %b want %b", k, ctl, C_DMW); end
      end
    end
    next_cycle();
    idle(); #1;
    checks++; if (halted !== 1'b1 || ctl !== C_HLT) begin errors++; $display("FAIL dmw_halted got %b/%b want 1/%b", halted, ctl, C_HLT); end
  endtask

  task automatic test_mid_halt_reset();
    checks++; if (stall_cnt !== 32'd302 || flush_cnt !== 32'd3) begin errors++; $display("FAIL pre_rst_cnts got %0d/%0d want 302/3", stall_cnt, flush_cnt); end
    next_cycle();
    idle(); rst = 1; #1;
    checks++; if (ctl !== C_RST || halted !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got %b/%b want %b/0", ctl, halted, C_RST); end
    next_cycle(); #1;
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL mid_rst_hold got %b want %b", ctl, C_RST); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL mid_rst_state got %0d/%0d/%b want 0/0/0", stall_cnt, flush_cnt, mem_timeout); end
    rst = 0; #1;
    checks++; if (ctl !== C_RUN || halted !== 1'b0) begin errors++; $display("FAIL mid_rst_run got %b/%b want %b/0", ctl, halted, C_RUN); end
    next_cycle(); #1;
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_no_stall got %0d want 0", stall_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_timeout();
    test_halt_resume();
    test_halt_branch();
    test_drain_mem_wait();
    test_mid_halt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
